// File: rtl/commit_monitor.sv
// Purpose: watches a CPU retire stream for one run (start..halt/timeout), counts cycles and retirements, captures commits in a FIFO.
// Latency: status/counters update on the edge that sees the event; FIFO pop data is registered, valid one cycle after rd_en.
// Backpressure: none toward the CPU; a commit arriving at a full FIFO without a same-cycle pop is dropped and flags overflow.
module commit_monitor #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     commit_valid,
   input  logic [4:0]               commit_rd,
   input  logic [DATA_W-1:0]        commit_data,
   input  logic                     commit_halt,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [4:0]               rd_rd,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         retired_cnt,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic                     running,
   output logic                     halted,
   output logic                     timed_out,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 5 + DATA_W;
   localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            in_run;
   logic            run_start;
   logic            do_pop;
   logic            do_push;
   logic            do_drop;
   logic            fifo_full;
   logic            halt_evt;
   logic            timeout_evt;

   // Decode of this cycle's events; the pop decision uses the occupancy before the edge,
   // so a commit pushed this cycle can never be the entry popped this cycle.
   always_comb begin
      in_run      = (state_q == S_RUN);
      run_start   = start && (state_q != S_RUN);
      fifo_full   = (fifo_count == FULL_CNT);
      do_pop      = rd_en && (fifo_count != '0);
      do_push     = in_run && commit_valid && (!fifo_full || do_pop);
      do_drop     = in_run && commit_valid && fifo_full && !do_pop;
      halt_evt    = in_run && commit_valid && commit_halt;
      timeout_evt = in_run && (cycle_cnt == LAST_CYC);
   end

   // Run-control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: halt wins over timeout on the same edge; start is ignored mid-run.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALTED, S_TIMEOUT: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            if (halt_evt)         state_d = S_HALTED;
            else if (timeout_evt) state_d = S_TIMEOUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status flags straight from the registered state.
   assign running   = (state_q == S_RUN);
   assign halted    = (state_q == S_HALTED);
   assign timed_out = (state_q == S_TIMEOUT);

   // Run statistics: cleared on a new run, frozen outside RUN, retire count saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         retired_cnt <= '0;
      end else if (run_start) begin
         cycle_cnt   <= '0;
         retired_cnt <= '0;
      end else if (in_run) begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (commit_valid && (retired_cnt != CNT_MAX))
            retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

   // FIFO pointers, occupancy and sticky overflow; a new run flushes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else if (run_start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      fifo_count <= fifo_count + (AW+1)'(1);
         else if (do_pop && !do_push) fifo_count <= fifo_count - (AW+1)'(1);
         if (do_drop) overflow <= 1'b1;
      end
   end

   // Capture storage; no reset needed since only entries below the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {commit_rd, commit_data};
   end

   // Registered pop port: data holds its last value whenever no pop happened.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_rd    <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= do_pop && !run_start;
         if (do_pop && !run_start) {rd_rd, rd_data} <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_commit_monitor.sv
// Purpose: randomized and directed stimulus for commit_monitor against a queue-based reference model.
// Latency: model advances once per rising edge; outputs are compared on the falling edge.
// Backpressure: expected pops go into a scoreboard queue drained by an independent monitor.
module tb_commit_monitor;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic        commit_halt;
   logic        rd_en;
   logic        rd_valid;
   logic [4:0]  rd_rd;
   logic [31:0] rd_data;
   logic [2:0]  fifo_count;
   logic [15:0] retired_cnt;
   logic [15:0] cycle_cnt;
   logic        running;
   logic        halted;
   logic        timed_out;
   logic        overflow;

   commit_monitor #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .commit_valid(commit_valid),
      .commit_rd(commit_rd), .commit_data(commit_data), .commit_halt(commit_halt),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_rd(rd_rd), .rd_data(rd_data),
      .fifo_count(fifo_count), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt),
      .running(running), .halted(halted), .timed_out(timed_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   // Reference model: a run is "active" between an accepted start and its halt/timeout.
   bit          m_run, m_halt, m_to, m_ovf, m_rdv;
   int          m_cyc, m_ret;
   logic [4:0]  m_rdrd;
   logic [31:0] m_rddata;
   ent_t        mq[$];
   ent_t        exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_run = 0; m_halt = 0; m_to = 0; m_ovf = 0; m_rdv = 0;
      m_cyc = 0; m_ret = 0; m_rdrd = '0; m_rddata = '0;
      mq.delete();
      exp_q.delete();
   endfunction

   // One rising edge of the specified behaviour, using the inputs held during the cycle.
   function automatic void model_step();
      ent_t e;
      if (rst) begin
         model_reset();
         return;
      end
      if (start && !m_run) begin
         mq.delete();
         m_cyc = 0; m_ret = 0; m_ovf = 0; m_rdv = 0;
         m_run = 1; m_halt = 0; m_to = 0;
         return;
      end
      m_rdv = 0;
      if (rd_en && mq.size() > 0) begin
         e = mq.pop_front();
         m_rdv = 1; m_rdrd = e.rd; m_rddata = e.d;
         exp_q.push_back(e);
      end
      if (m_run) begin
         m_cyc++;
         if (commit_valid) begin
            if (m_ret < 65535) m_ret++;
            if (mq.size() < DEPTH) begin
               e.rd = commit_rd; e.d = commit_data;
               mq.push_back(e);
            end else m_ovf = 1;
         end
         if (commit_valid && commit_halt) begin
            m_run = 0; m_halt = 1;
         end else if (m_cyc == TIMEOUT) begin
            m_run = 0; m_to = 1;
         end
      end
   endfunction

   // Monitor: compare status against the model and drain the pop scoreboard.
   always @(negedge clk) begin
      ent_t e;
      chk("running", running, m_run);
      chk("halted", halted, m_halt);
      chk("timed_out", timed_out, m_to);
      chk("overflow", overflow, m_ovf);
      chk("fifo_count", fifo_count, mq.size());
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("retired_cnt", retired_cnt, m_ret);
      chk("rd_valid", rd_valid, m_rdv);
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL pop_unexpected: got rd=%0d data=%0h, expected no pop", rd_rd, rd_data);
         end else begin
            e = exp_q.pop_front();
            chk("pop_rd", rd_rd, e.rd);
            chk("pop_data", rd_data, e.d);
         end
      end else begin
         chk("hold_rd", rd_rd, m_rdrd);
         chk("hold_data", rd_data, m_rddata);
      end
   end

   task automatic cyc(input bit s, input bit cv, input logic [4:0] rd,
                      input logic [31:0] d, input bit h, input bit re);
      @(negedge clk);
      start = s; commit_valid = cv; commit_rd = rd; commit_data = d;
      commit_halt = h; rd_en = re;
      @(posedge clk);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 32'd0, 0, 0);
   endtask

   task automatic pops(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 32'd0, 0, 1);
   endtask

   // Asynchronous reset pulse in the middle of a cycle; outputs must clear before any edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1; start = 0; commit_valid = 0; rd_en = 0; commit_halt = 0;
      #1;
      chk("rst_running", running, 0);
      chk("rst_halted", halted, 0);
      chk("rst_timed_out", timed_out, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_retired_cnt", retired_cnt, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overflow", overflow, 0);
      model_reset();
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      model_step();
   endtask

   initial begin
      rst = 1; start = 0; commit_valid = 0; commit_rd = '0; commit_data = '0;
      commit_halt = 0; rd_en = 0;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      model_step();

      // Three commits then a halt in RUN cycle 6, drained in order.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      idle(1);
      cyc(0, 1, 5'd1, 32'h11, 0, 0);
      cyc(0, 1, 5'd2, 32'h22, 0, 0);
      cyc(0, 1, 5'd3, 32'h33, 0, 0);
      idle(1);
      cyc(0, 1, 5'd4, 32'h44, 1, 0);
      #1;
      chk("halt_flag", halted, 1);
      chk("halt_retired", retired_cnt, 4);
      chk("halt_cycles", cycle_cnt, 6);
      cyc(0, 0, 5'd0, 32'd0, 0, 1);
      #1;
      chk("first_pop_rd", rd_rd, 1);
      chk("first_pop_data", rd_data, 32'h11);
      pops(3);
      idle(2);

      // Watchdog: no commits for a whole run, later commits ignored.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      idle(TIMEOUT - 1);
      #1;
      chk("pre_timeout", timed_out, 0);
      idle(1);
      #1;
      chk("timeout_flag", timed_out, 1);
      chk("timeout_cycles", cycle_cnt, TIMEOUT);
      for (int i = 0; i < 3; i++) cyc(0, 1, 5'(i), $urandom, 0, 0);
      #1;
      chk("post_timeout_retired", retired_cnt, 0);

      // Halt exactly on the last watchdog cycle beats the timeout.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      idle(TIMEOUT - 1);
      cyc(0, 1, 5'd9, 32'h99, 1, 0);
      #1;
      chk("edge_halt", halted, 1);
      chk("edge_no_timeout", timed_out, 0);
      pops(1);

      // Overflow: DEPTH+2 commits with no pops keep only the first DEPTH.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 5'(i + 1), $urandom, 0, 0);
      #1;
      chk("ovf_count", fifo_count, DEPTH);
      chk("ovf_flag", overflow, 1);
      pops(DEPTH);
      idle(TIMEOUT);

      // Full FIFO with simultaneous pop and push: no drop, no overflow.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 5'(i + 10), $urandom, 0, 0);
      cyc(0, 1, 5'd20, $urandom, 0, 1);
      #1;
      chk("full_swap_count", fifo_count, DEPTH);
      chk("full_swap_ovf", overflow, 0);
      pops(DEPTH);

      // Reset in the middle of a run with five commits captured.
      do_reset();
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 5'(i + 1), $urandom, 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 1, 5'(i), $urandom, 0, 0);
      #1;
      chk("post_rst_cycles", cycle_cnt, 0);
      chk("post_rst_idle", running, 0);

      // Restart from TIMEOUT with unread entries flushes the FIFO.
      cyc(1, 0, 5'd0, 32'd0, 0, 0);
      cyc(0, 1, 5'd5, 32'h55, 0, 0);
      cyc(0, 1, 5'd6, 32'h66, 0, 0);
      idle(TIMEOUT);
      #1;
      chk("restart_pre_count", fifo_count, 2);
      chk("restart_pre_to", timed_out, 1);
      cyc(1, 0, 5'd0, 32'd0, 0, 1);
      #1;
      chk("restart_running", running, 1);
      chk("restart_count", fifo_count, 0);
      chk("restart_cycles", cycle_cnt, 0);
      chk("restart_rd_valid", rd_valid, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom), $urandom, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0);
      end
      idle(2);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/commit_monitor.md
COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the commit data width.
REQ-002 SHALL have parameter DEPTH, default 4 (power of 2), meaning the capture FIFO entries.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the cycle and retire counter width.
REQ-004 SHALL have parameter TIMEOUT, default 40, meaning the watchdog limit in cycles.
REQ-005 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst  input  1  the asynchronous, active-high reset.
REQ-007 SHALL have start  input  1  a one-cycle request to begin a monitoring run.
REQ-008 SHALL have commit_valid  input  1  the CPU retire strobe.
REQ-009 SHALL have commit_rd  input  5  the retired destination register.
REQ-010 SHALL have commit_data  input  DATA_W  the retired result value.
REQ-011 SHALL have commit_halt  input  1  a flag marking the retired instruction as a halt.
REQ-012 SHALL have rd_en  input  1  the FIFO pop request.
REQ-013 SHALL have rd_valid  output  1  a flag that rd_rd and rd_data hold a popped entry.
REQ-014 SHALL have rd_rd / rd_data  output  5 / DATA_W  the popped commit.
REQ-015 SHALL have fifo_count  output  log2(DEPTH)+1  the current FIFO occupancy.
REQ-016 SHALL have retired_cnt / cycle_cnt  output  CNT_W  the run statistics.
REQ-017 SHALL have running / halted / timed_out / overflow  output  1 each  the status flags.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN, HALTED and TIMEOUT; running=RUN, halted=HALTED and timed_out=TIMEOUT, each decoded from registered state.
REQ-019 SHALL move IDLE->RUN on start; start in RUN SHALL be ignored.
REQ-020 SHALL move HALTED or TIMEOUT->RUN on start, in the same edge clearing retired_cnt, cycle_cnt, overflow and the FIFO (pointers, count) and deasserting rd_valid.
REQ-021 SHALL, in RUN, increment cycle_cnt by 1 every cycle, with the first RUN cycle counting as 1.
REQ-022 SHALL, in RUN, increment retired_cnt on commit_valid, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL, in RUN, move to HALTED on commit_valid&&commit_halt; the halt commit SHALL be counted and captured.
REQ-024 SHALL, in RUN, move to TIMEOUT when cycle_cnt==TIMEOUT-1 at the edge (cycle_cnt then reads TIMEOUT) and no halt commits that cycle.
REQ-025 SHALL give halt priority over timeout when both occur on the same edge.
REQ-026 SHALL, in IDLE/HALTED/TIMEOUT, freeze both counters and ignore commit_valid.
REQ-027 SHALL, in RUN, push {commit_rd, commit_data} on commit_valid.
REQ-028 SHALL, when the FIFO is full with no pop that cycle, drop the commit and set overflow (sticky until start or rst).
REQ-029 SHALL, when the FIFO is full and a pop and push occur in the same cycle, perform both, keep the count unchanged and leave overflow unset.
REQ-030 SHALL treat rd_en on an empty FIFO (count 0 before the edge) as a no-op with rd_valid=0 next cycle; a same-cycle push SHALL NOT be readable that cycle.
REQ-031 SHALL register the pop with 1-cycle latency: rd_en at edge N gives rd_valid=1 and oldest-entry data after edge N; rd_valid=0 in any cycle following an edge without a successful pop.
REQ-032 SHALL keep the FIFO readable in every state.
REQ-033 SHALL wrap read/write pointers modulo DEPTH, with fifo_count ranging 0..DEPTH.
REQ-034 SHALL hold rd_rd/rd_data at their last value while rd_valid=0.

Reset
REQ-035 SHALL, while rst is high, asynchronously force state=IDLE, all counters=0, FIFO empty, fifo_count=0 and rd_valid=rd_rd=rd_data=overflow=0.
REQ-036 SHALL abort a run on rst asserted in RUN with no further pushes or counts, and SHALL require a new start after rst deasserts.

Verification
REQ-037 SHALL verify: start, then 3 commits (rd=1,2,3, data=0x11,0x22,0x33), halt on the 4th in RUN cycle 6 -> halted=1, retired_cnt=4, cycle_cnt=6, FIFO pops return 1/0x11, 2/0x22, 3/0x33, then the halt entry.
REQ-038 SHALL verify: start, no commits -> timed_out=1 after edge 40 with cycle_cnt=40, and commits afterward ignored.
REQ-039 SHALL verify: halt commit on the cycle cycle_cnt==39 -> halted=1, timed_out=0.
REQ-040 SHALL verify: DEPTH+2 commits with no pops -> fifo_count=4, overflow=1, pops return the first 4; full FIFO with simultaneous rd_en+commit -> count stays 4, overflow unchanged.
REQ-041 SHALL verify: rst pulse mid-run after 5 commits -> all outputs 0, state IDLE immediately, no counting until start.
REQ-042 SHALL verify: start in TIMEOUT with 2 entries unread -> FIFO emptied, counters 0, running=1 next cycle.
